row_accum_scheduler: RTL and testbench
======================================

Name: row_accum_scheduler

Overview:
- Sequences one 8-wide row-accumulation datapath (adder tree + final accumulator) through a matrix-vector product.
- Accepts row chunks of NI 32-bit operands over a valid/ready stream and drives the datapath's operand bus, start and first-chunk token.
- Waits out the fixed pipeline drain and captures one 32-bit row result per row, presented on a valid/ready result port.
- Sits between the row-fetch buffer and the datapath, one level above it.

Parameters:
- NI, 8, operands per chunk (32 bits each).
- CHUNKS_PER_ROW, 4, chunks that make up one row; legal range 1..255.
- DRAIN_LAT, 14, cycles from the last chunk issued to the row sum being valid on dp_sum.
- NUM_ROWS, 16, rows per job; legal range 1..65535.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- job_go  in  1  one-cycle pulse that starts a job of NUM_ROWS rows; ignored unless state is IDLE.
- job_busy  out  1  high from the cycle after an accepted job_go until the last result handshake.
- job_done  out  1  one-cycle pulse on the cycle after the last result handshake.
- chunk_valid  in  1  chunk available.
- chunk_data  in  NI*32  chunk operands.
- chunk_ready  out  1  scheduler accepts the chunk this cycle.
- dp_row_input  out  NI*32  registered operand bus to the datapath.
- dp_start  out  1  datapath enable; held high for the whole job.
- dp_first  out  1  one-cycle token aligned with the first chunk of each row.
- dp_sum  in  32  datapath accumulator output.
- res_valid  out  1  row result valid.
- res_data  out  32  captured row sum.
- res_row  out  16  index of the row, 0-based.
- res_ready  in  1  result consumer ready.
- stat_rows  out  16  rows completed; only under ROW_STATS_EN.
- stat_bubbles  out  16  bubble cycles; only under ROW_STATS_EN.

Behaviour:
- Reset values: job_busy, job_done, chunk_ready, dp_start, dp_first and res_valid are 0; dp_row_input, res_data and res_row are 0; state is IDLE; all counters are 0.
- Reset asserted mid-job aborts the job immediately. A partial result is never emitted.
- FSM states: IDLE, FEED, DRAIN, HOLD.
- IDLE -> FEED on job_go. Clears the row and chunk counters and sets dp_start=1.
- FEED:
  - chunk_ready=1.
  - On chunk_valid&&chunk_ready, the chunk is registered onto dp_row_input (1-cycle latency).
  - dp_first=1 in the same cycle as the registered first chunk (chunk count 0), else 0.
  - The chunk counter increments on each accept.
  - Accepting chunk CHUNKS_PER_ROW-1 -> DRAIN, chunk counter cleared, drain counter loaded with DRAIN_LAT-1.
  - A cycle with chunk_valid=0 in FEED is a bubble: dp_row_input is driven to all zeros so the accumulator adds 0.
- DRAIN:
  - chunk_ready=0.
  - dp_row_input is held at zero.
  - The counter decrements each cycle. At 0, res_data<=dp_sum, res_row<=row counter, res_valid<=1 -> HOLD.
- HOLD:
  - res_valid stays high and res_data is stable until res_valid&&res_ready.
  - On handshake, res_valid<=0 and the row counter increments.
  - If the completed row was NUM_ROWS-1: -> IDLE, dp_start<=0, job_busy<=0, job_done pulses.
  - Otherwise -> FEED.
- Back-to-back rows: with res_ready held high, row issue period = CHUNKS_PER_ROW + DRAIN_LAT + 1 cycles. Rows are not overlapped, so the accumulator never mixes rows.
- CHUNKS_PER_ROW=1: FEED lasts exactly one accepted chunk, which carries dp_first.
- job_go while busy is ignored. job_go coincident with rst_n=0 is ignored.
- Counters are unsigned. The row counter is 16 bits and never wraps within a job, because of the NUM_ROWS limit.

Optional Feature:
- Macro: ROW_STATS_EN.
- Defined:
  - stat_rows counts result handshakes.
  - stat_bubbles counts FEED cycles with chunk_valid=0.
  - Both clear on an accepted job_go and on reset, and saturate at 16'hFFFF.
- Undefined: the counters are not built and both ports are tied to 0.

Decomposition:
- Shared package row_sched_pkg holds:
  - state enum (IDLE=0, FEED=1, DRAIN=2, HOLD=3);
  - default constants NI_DEF=8 and DRAIN_LAT_DEF=14;
  - operand width constant 32.
- One natural sub-module, sched_down_counter: a loadable down-counter with a zero flag, used for the drain timer.

Test Plan:
- NI=8, CHUNKS_PER_ROW=4, NUM_ROWS=2, chunk_valid always high, res_ready high -> dp_first high on chunk 0 of each row; res_valid first asserts 4+14 cycles after the first accept; res_row 0 then 1; job_done 19 cycles after the second row starts.
- Insert 3 invalid cycles mid-row -> dp_row_input is 0 during those 3 cycles; res_valid is delayed by 3 cycles; stat_bubbles=3 with ROW_STATS_EN.
- Hold res_ready low for 10 cycles in HOLD -> res_data and res_valid are stable; chunk_ready=0 throughout; the next row starts the cycle after the handshake.
- Assert rst_n=0 during DRAIN of row 1 -> next cycle all outputs are at reset values; no res_valid is emitted; a new job_go runs cleanly from row 0.
- Pulse job_go during FEED -> no effect; row and chunk counts are unchanged.
- CHUNKS_PER_ROW=1, NUM_ROWS=3 -> each row has one chunk with dp_first=1; stat_rows=3 at job_done.

Source files
------------

// File: rtl/row_sched_pkg.sv
// Shared types and constants for the row-accumulation scheduler.
package row_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } sched_state_e;

    localparam int NI_DEF        = 8;
    localparam int DRAIN_LAT_DEF = 14;
    localparam int OPND_W        = 32;

endpackage

// File: rtl/row_accum_scheduler_down_counter.sv
// Loadable down-counter with a zero flag; times the datapath drain.
module sched_down_counter
    import row_sched_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/row_accum_scheduler.sv
// Feeds row chunks to an 8-wide accumulate datapath and captures one sum per row.
// Optional statistics counters are built when ROW_STATS_EN is defined.
module row_accum_scheduler
    import row_sched_pkg::*;
#(
    parameter int NI             = NI_DEF,
    parameter int CHUNKS_PER_ROW = 4,
    parameter int DRAIN_LAT      = DRAIN_LAT_DEF,
    parameter int NUM_ROWS       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 job_go,
    output logic                 job_busy,
    output logic                 job_done,
    input  logic                 chunk_valid,
    input  logic [NI*OPND_W-1:0] chunk_data,
    output logic                 chunk_ready,
    output logic [NI*OPND_W-1:0] dp_row_input,
    output logic                 dp_start,
    output logic                 dp_first,
    input  logic [OPND_W-1:0]    dp_sum,
    output logic                 res_valid,
    output logic [OPND_W-1:0]    res_data,
    output logic [15:0]          res_row,
    input  logic                 res_ready,
    output logic [15:0]          stat_rows,
    output logic [15:0]          stat_bubbles
);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] FEED  = ST_FEED;
    localparam logic [1:0] DRAIN = ST_DRAIN;
    localparam logic [1:0] HOLD  = ST_HOLD;

    // Chunk stream: a beat transfers when chunk_valid and chunk_ready are both high
    // on a rising edge; result port likewise transfers on res_valid && res_ready.
    logic [1:0]  state;
    logic [7:0]  chunk_cnt;
    logic [15:0] row_cnt;
    logic        accept;
    logic        last_chunk;
    logic        last_row;
    logic        res_hs;
    logic        drain_load;
    logic        drain_zero;

    assign chunk_ready = (state == FEED);
    assign accept      = chunk_valid && chunk_ready;
    assign last_chunk  = (chunk_cnt == 8'(CHUNKS_PER_ROW - 1));
    assign last_row    = (row_cnt == 16'(NUM_ROWS - 1));
    assign res_hs      = res_valid && res_ready;
    assign drain_load  = accept && last_chunk;

    sched_down_counter #(.W(16)) u_drain (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (drain_load),
        .load_val (16'(DRAIN_LAT - 1)),
        .dec      (state == DRAIN),
        .zero     (drain_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            chunk_cnt    <= '0;
            row_cnt      <= '0;
            job_busy     <= 1'b0;
            job_done     <= 1'b0;
            dp_start     <= 1'b0;
            dp_first     <= 1'b0;
            dp_row_input <= '0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_row      <= '0;
        end else begin
            job_done     <= 1'b0;
            dp_first     <= 1'b0;
            // Anything not carrying a real chunk adds zero into the accumulator.
            dp_row_input <= '0;
            case (state)
                IDLE: begin
                    if (job_go) begin
                        state     <= FEED;
                        dp_start  <= 1'b1;
                        job_busy  <= 1'b1;
                        row_cnt   <= '0;
                        chunk_cnt <= '0;
                    end
                end
                FEED: begin
                    if (accept) begin
                        dp_row_input <= chunk_data;
                        dp_first     <= (chunk_cnt == 8'd0);
                        if (last_chunk) begin
                            chunk_cnt <= '0;
                            state     <= DRAIN;
                        end else begin
                            chunk_cnt <= chunk_cnt + 8'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_zero) begin
                        res_data  <= dp_sum;
                        res_row   <= row_cnt;
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (res_hs) begin
                        res_valid <= 1'b0;
                        row_cnt   <= row_cnt + 16'd1;
                        if (last_row) begin
                            state    <= IDLE;
                            dp_start <= 1'b0;
                            job_busy <= 1'b0;
                            job_done <= 1'b1;
                        end else begin
                            state <= FEED;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ROW_STATS_EN
    logic [15:0] rows_q;
    logic [15:0] bubbles_q;

    always_ff @(posedge clk) begin
        if (!rst_n || ((state == IDLE) && job_go)) begin
            rows_q    <= '0;
            bubbles_q <= '0;
        end else begin
            if (res_hs && (rows_q != 16'hFFFF)) begin
                rows_q <= rows_q + 16'd1;
            end
            if ((state == FEED) && !chunk_valid && (bubbles_q != 16'hFFFF)) begin
                bubbles_q <= bubbles_q + 16'd1;
            end
        end
    end

    assign stat_rows    = rows_q;
    assign stat_bubbles = bubbles_q;
`else
    assign stat_rows    = '0;
    assign stat_bubbles = '0;
`endif

endmodule

// File: tb/tb_row_accum_scheduler.sv
// Bench for row_accum_scheduler: a 4-chunk/2-row instance driven from a vector table
// and a 1-chunk/3-row instance, each with a behavioural accumulate datapath.
module tb_row_accum_scheduler;

    localparam int W = 256;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic          job_go_a, job_busy_a, job_done_a, chunk_valid_a, chunk_ready_a;
    logic [W-1:0]  chunk_data_a, dp_row_input_a;
    logic          dp_start_a, dp_first_a, res_valid_a, res_ready_a;
    logic [31:0]   dp_sum_a, res_data_a;
    logic [15:0]   res_row_a, stat_rows_a, stat_bubbles_a;

    logic          job_go_b, job_busy_b, job_done_b, chunk_valid_b, chunk_ready_b;
    logic [W-1:0]  chunk_data_b, dp_row_input_b;
    logic          dp_start_b, dp_first_b, res_valid_b, res_ready_b;
    logic [31:0]   dp_sum_b, res_data_b;
    logic [15:0]   res_row_b, stat_rows_b, stat_bubbles_b;

    logic [47:0] exp_q[$];
    logic [47:0] exp_qb[$];

    typedef struct {
        int bub;
        int stall;
        int go_mid;
        int abort;
        int exp_lat;
        int exp_bub;
    } vec_t;

    vec_t tbl[6];

    row_accum_scheduler #(.NI(8), .CHUNKS_PER_ROW(4), .DRAIN_LAT(14), .NUM_ROWS(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .job_go(job_go_a), .job_busy(job_busy_a), .job_done(job_done_a),
        .chunk_valid(chunk_valid_a), .chunk_data(chunk_data_a), .chunk_ready(chunk_ready_a),
        .dp_row_input(dp_row_input_a), .dp_start(dp_start_a), .dp_first(dp_first_a), .dp_sum(dp_sum_a),
        .res_valid(res_valid_a), .res_data(res_data_a), .res_row(res_row_a), .res_ready(res_ready_a),
        .stat_rows(stat_rows_a), .stat_bubbles(stat_bubbles_a)
    );

    row_accum_scheduler #(.NI(8), .CHUNKS_PER_ROW(1), .DRAIN_LAT(14), .NUM_ROWS(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .job_go(job_go_b), .job_busy(job_busy_b), .job_done(job_done_b),
        .chunk_valid(chunk_valid_b), .chunk_data(chunk_data_b), .chunk_ready(chunk_ready_b),
        .dp_row_input(dp_row_input_b), .dp_start(dp_start_b), .dp_first(dp_first_b), .dp_sum(dp_sum_b),
        .res_valid(res_valid_b), .res_data(res_data_b), .res_row(res_row_b), .res_ready(res_ready_b),
        .stat_rows(stat_rows_b), .stat_bubbles(stat_bubbles_b)
    );

    // Clock and cycle index (cyc holds the index of the most recent rising edge).
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] lanesum(input logic [W-1:0] v);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) s = s + v[i*32 +: 32];
        return s;
    endfunction

    // Datapath stand-in: accumulator restarted by dp_first, then a 12-stage delay so the
    // full sum is on dp_sum exactly 14 cycles after the last chunk is registered.
    logic [31:0] acc_a, acc_b;
    logic [31:0] pipe_a[12];
    logic [31:0] pipe_b[12];
    always @(posedge clk) begin
        acc_a <= dp_first_a ? lanesum(dp_row_input_a) : acc_a + lanesum(dp_row_input_a);
        acc_b <= dp_first_b ? lanesum(dp_row_input_b) : acc_b + lanesum(dp_row_input_b);
        pipe_a[0] <= acc_a;
        pipe_b[0] <= acc_b;
        for (int i = 1; i < 12; i++) begin
            pipe_a[i] <= pipe_a[i-1];
            pipe_b[i] <= pipe_b[i-1];
        end
    end
    assign dp_sum_a = pipe_a[11];
    assign dp_sum_b = pipe_b[11];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_ctrl"}, {job_busy_a, job_done_a, chunk_ready_a, dp_start_a, dp_first_a, res_valid_a}, 0);
        check({tag, "_operands"}, dp_row_input_a, 0);
        check({tag, "_result"}, {res_row_a, res_data_a}, 0);
        check({tag, "_stats"}, {stat_rows_a, stat_bubbles_a}, 0);
    endtask

    // Drives one 4-chunk row; bubbles are inserted before chunk 2.
    task automatic feed_row_a(input int row, input int bub, input int go_mid, output int first_edge);
        int c, b;
        logic [W-1:0] d;
        logic [31:0] sum;
        c = 0; b = 0; sum = '0; first_edge = 0;
        while (c < 4) begin
            @(negedge clk);
            check("chunk_ready_feed", chunk_ready_a, 1);
            for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
            chunk_data_a  = d;
            chunk_valid_a = !(c == 2 && b < bub);
            job_go_a      = (go_mid != 0 && c == 1);
            @(posedge clk); #1;
            check("dp_row_input", dp_row_input_a, chunk_valid_a ? d : '0);
            check("dp_first", dp_first_a, chunk_valid_a && c == 0);
            if (chunk_valid_a) begin
                if (c == 0) first_edge = cyc;
                sum = sum + lanesum(d);
                c++;
            end else begin
                b++;
            end
        end
        job_go_a = 1'b0;
        chunk_valid_a = 1'b0;
        exp_q.push_back({16'(row), sum});
    endtask

    task automatic run_job_a(input vec_t v);
        int a_edge[2];
        int guard;
        logic [47:0] e;
        logic [31:0] held;
        logic ok;
        @(negedge clk);
        job_go_a = 1'b1;
        @(posedge clk); #1;
        job_go_a = 1'b0;
        check("busy_after_go", job_busy_a, 1);
        check("start_after_go", dp_start_a, 1);
        for (int row = 0; row < 2; row++) begin
            feed_row_a(row, (row == 0) ? v.bub : 0, (row == 0) ? v.go_mid : 0, a_edge[row]);
            if (row == 1 && v.abort != 0) begin
                repeat (5) @(negedge clk);
                rst_n = 1'b0;
                @(posedge clk); #1;
                check_reset_a("abort");
                void'(exp_q.pop_back());
                @(negedge clk);
                rst_n = 1'b1;
                ok = 1'b1;
                repeat (25) begin
                    @(posedge clk); #1;
                    if (res_valid_a || job_busy_a) ok = 1'b0;
                end
                check("abort_quiet", ok, 1);
                return;
            end
            res_ready_a = !(row == 0 && v.stall > 0);
            ok = 1'b1;
            guard = 0;
            do begin
                @(posedge clk); #1;
                guard++;
                if (!res_valid_a && (chunk_ready_a || dp_row_input_a != '0)) ok = 1'b0;
            end while (!res_valid_a && guard < 64);
            check("drain_quiet", ok, 1);
            if (!res_valid_a) begin
                check("res_timeout", res_valid_a, 1);
                res_ready_a = 1'b0;
                return;
            end
            // Edge on which the consumer first samples res_valid, counted from the first accept.
            check("res_latency", cyc - a_edge[row] + 1, (row == 0) ? v.exp_lat : 18);
            if (row == 0 && v.stall > 0) begin
                held = res_data_a;
                ok = 1'b1;
                repeat (v.stall) begin
                    @(posedge clk); #1;
                    if (!res_valid_a || res_data_a !== held || chunk_ready_a) ok = 1'b0;
                end
                check("hold_stable", ok, 1);
                res_ready_a = 1'b1;
            end
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("res_row", res_row_a, e[47:32]);
                check("res_data", res_data_a, e[31:0]);
            end
            @(posedge clk); #1;
            res_ready_a = 1'b0;
            check("res_release", res_valid_a, 0);
            if (row == 0) begin
                check("next_row_ready", chunk_ready_a, 1);
            end else begin
                check("done_pulse", job_done_a, 1);
                check("done_latency", cyc - a_edge[1] + 1, 19);
                check("busy_clear", {job_busy_a, dp_start_a}, 0);
`ifdef ROW_STATS_EN
                check("stat_rows", stat_rows_a, 2);
                check("stat_bubbles", stat_bubbles_a, v.exp_bub);
`else
                check("stat_rows", stat_rows_a, 0);
                check("stat_bubbles", stat_bubbles_a, 0);
`endif
                @(posedge clk); #1;
                check("done_single", job_done_a, 0);
            end
        end
        if (v.bub == 0 && v.stall == 0) check("row_period", a_edge[1] - a_edge[0], 19);
    endtask

    task automatic run_b();
        int a, guard;
        logic [W-1:0] d;
        logic [47:0] e;
        @(negedge clk);
        job_go_b = 1'b1;
        @(posedge clk); #1;
        job_go_b = 1'b0;
        for (int row = 0; row < 3; row++) begin
            @(negedge clk);
            check("b_chunk_ready", chunk_ready_b, 1);
            for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
            chunk_data_b  = d;
            chunk_valid_b = 1'b1;
            @(posedge clk); #1;
            a = cyc;
            chunk_valid_b = 1'b0;
            check("b_dp_first", dp_first_b, 1);
            check("b_dp_row_input", dp_row_input_b, d);
            exp_qb.push_back({16'(row), lanesum(d)});
            res_ready_b = 1'b1;
            guard = 0;
            do begin
                @(posedge clk); #1;
                guard++;
            end while (!res_valid_b && guard < 64);
            check("b_res_latency", cyc - a + 1, 15);
            if (exp_qb.size() != 0) begin
                e = exp_qb.pop_front();
                check("b_res_row", res_row_b, e[47:32]);
                check("b_res_data", res_data_b, e[31:0]);
            end
            @(posedge clk); #1;
            res_ready_b = 1'b0;
        end
        check("b_done_pulse", job_done_b, 1);
`ifdef ROW_STATS_EN
        check("b_stat_rows", stat_rows_b, 3);
`else
        check("b_stat_rows", stat_rows_b, 0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500000 ns");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{bub: 0, stall: 0,  go_mid: 0, abort: 0, exp_lat: 18, exp_bub: 0};
        tbl[1] = '{bub: 3, stall: 0,  go_mid: 0, abort: 0, exp_lat: 21, exp_bub: 3};
        tbl[2] = '{bub: 0, stall: 10, go_mid: 0, abort: 0, exp_lat: 18, exp_bub: 0};
        tbl[3] = '{bub: 1, stall: 2,  go_mid: 1, abort: 0, exp_lat: 19, exp_bub: 1};
        tbl[4] = '{bub: 0, stall: 0,  go_mid: 0, abort: 1, exp_lat: 18, exp_bub: 0};
        tbl[5] = '{bub: 2, stall: 0,  go_mid: 0, abort: 0, exp_lat: 20, exp_bub: 2};

        rst_n = 1'b0;
        job_go_a = 1'b0; chunk_valid_a = 1'b0; chunk_data_a = '0; res_ready_a = 1'b0;
        job_go_b = 1'b0; chunk_valid_b = 1'b0; chunk_data_b = '0; res_ready_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_a("por");
        check("b_por_ctrl", {job_busy_b, job_done_b, chunk_ready_b, dp_start_b, dp_first_b, res_valid_b}, 0);

        // job_go raised while reset is held must not start a job.
        @(negedge clk);
        job_go_a = 1'b1;
        @(posedge clk); #1;
        check("go_in_reset_busy", job_busy_a, 0);
        @(negedge clk);
        job_go_a = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("go_in_reset_idle", {job_busy_a, chunk_ready_a}, 0);

        for (int t = 0; t < 6; t++) run_job_a(tbl[t]);
        run_b();

        check("scoreboard_drained", exp_q.size() + exp_qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
